// File: rtl/serial_full_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The controller side drives start and operands; the adder side returns status and result.
interface serial_full_adder_if #(
    parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop, one bit per clock.
// Result is published on the edge that enters DONE and held until the next completion.
module serial_full_adder #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_full_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, work_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic fa_bit, fa_carry, last_bit, accept;

  assign fa_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign fa_carry = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
  assign last_bit = (cnt_reg == LAST);
  // start is only honoured outside SHIFT, so a running operation cannot be disturbed
  assign accept   = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.carry_in;
      work_reg  <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == SHIFT) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry_reg <= fa_carry;
      // new bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts
      work_reg  <= {fa_bit, work_reg[WIDTH-1:1]};
      if (last_bit) begin
        sum_reg  <= {fa_bit, work_reg[WIDTH-1:1]};
        cout_reg <= fa_carry;
      end else begin
        cnt_reg  <= cnt_reg + CW'(1);
      end
    end
  end

  assign bus.busy      = (state_reg == SHIFT);
  assign bus.done      = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.carry_out = cout_reg;
endmodule
